// File: rtl/acdiv_pkg.sv
// Shared types and constants for the accuracy-controllable divider.
package acdiv_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 8;

  localparam logic [QUOT_W-1:0] ERR_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;
endpackage

// File: rtl/acdiv_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract the divisor.
module acdiv_step
  import acdiv_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr_i,
  input  logic                 dvd_bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   pr_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W+1:0] shifted;

  always_comb begin
    shifted = {pr_i, dvd_bit_i};
    q_bit_o = (shifted >= {2'b00, divisor_i});
    pr_o    = q_bit_o ? (DIVISOR_W+1)'(shifted - {2'b00, divisor_i})
                      : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/accuracy_controllable_divider.sv
// 16/8 restoring divider; mask=0 stops early and fills the skipped low quotient bits.
// Optional ACDIV_ROUND_EN: fill the skipped field with a midpoint (1 then zeros) instead of zeros.
module accuracy_controllable_divider
  import acdiv_pkg::*;
#(
  parameter int APPROX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  mask,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_err
);

  localparam logic [2:0] APPROX_IDX = 3'(APPROX_BITS);
`ifdef ACDIV_ROUND_EN
  localparam logic [QUOT_W-1:0] ROUND_FILL = QUOT_W'(1) << (APPROX_BITS - 1);
`else
  localparam logic [QUOT_W-1:0] ROUND_FILL = '0;
`endif

  state_e                 state_q, state_d;
  logic                   mask_q;
  logic [DIVISOR_W-1:0]   divisor_q;
  logic [7:0]             dvd_lo_q;
  logic [DIVISOR_W:0]     pr_q;
  logic [2:0]             idx_q;
  logic [QUOT_W-1:0]      qwork_q;
  logic [QUOT_W-1:0]      quot_q;
  logic [DIVISOR_W-1:0]   rem_q;
  logic                   err_q;

  logic                   start_err;
  logic                   last_step;
  logic [DIVISOR_W:0]     step_pr;
  logic                   step_q;
  logic [QUOT_W-1:0]      final_quot;

  // Overflow: the quotient would not fit in 8 bits when the high byte already reaches the divisor.
  assign start_err  = (divisor == '0) || (dividend[15:8] >= divisor);
  assign last_step  = (idx_q == (mask_q ? 3'd0 : APPROX_IDX));
  assign final_quot = qwork_q | (QUOT_W'(step_q) << idx_q) | (mask_q ? '0 : ROUND_FILL);

  acdiv_step u_step (
    .pr_i      (pr_q),
    .dvd_bit_i (dvd_lo_q[idx_q]),
    .divisor_i (divisor_q),
    .pr_o      (step_pr),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = start_err ? DONE : CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= 1'b0;
      divisor_q <= '0;
      dvd_lo_q  <= '0;
      pr_q      <= '0;
      idx_q     <= '0;
      qwork_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mask_q    <= mask;
          divisor_q <= divisor;
          dvd_lo_q  <= dividend[7:0];
          pr_q      <= {1'b0, dividend[15:8]};
          idx_q     <= 3'd7;
          qwork_q   <= '0;
          if (start_err) begin
            quot_q <= ERR_QUOT;
            rem_q  <= (divisor == '0) ? dividend[7:0] : '0;
            err_q  <= 1'b1;
          end
        end
        CALC: begin
          pr_q           <= step_pr;
          qwork_q[idx_q] <= step_q;
          idx_q          <= idx_q - 3'd1;
          if (last_step) begin
            quot_q <= final_quot;
            rem_q  <= mask_q ? step_pr[DIVISOR_W-1:0] : '0;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_err   = err_q;

endmodule

// File: tb/tb_accuracy_controllable_divider.sv
// Randomised and directed bench for accuracy_controllable_divider against an arithmetic reference model.
module tb_accuracy_controllable_divider;

  localparam int A = 3;
`ifdef ACDIV_ROUND_EN
  localparam logic [7:0] APPROX_Q = 8'd140;
`else
  localparam logic [7:0] APPROX_Q = 8'd136;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        mask = 1'b0;
  logic        busy, done, div_err;
  logic [7:0]  quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         got;
    int         lat;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    logic       done_after;
    logic       busy_after;
    logic [7:0] q_after;
    logic [7:0] r_after;
    logic       e_after;
  } res_t;

  accuracy_controllable_divider #(.APPROX_BITS(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .mask      (mask),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, then truncate/fill the low quotient bits for approximate mode.
  task automatic model(input logic [15:0] a, input logic [7:0] b, input logic m,
                       output logic [7:0] q, output logic [7:0] r, output logic e, output int lat);
    int quo;
    if (b == 8'd0) begin
      q = 8'hFF; r = a[7:0]; e = 1'b1; lat = 1;
    end else begin
      quo = int'(a) / int'(b);
      if (quo > 255) begin
        q = 8'hFF; r = 8'd0; e = 1'b1; lat = 1;
      end else if (m) begin
        q = quo[7:0]; r = 8'(int'(a) % int'(b)); e = 1'b0; lat = 9;
      end else begin
        quo = (quo >> A) << A;
`ifdef ACDIV_ROUND_EN
        quo = quo + (1 << (A - 1));
`endif
        q = quo[7:0]; r = 8'd0; e = 1'b0; lat = 9 - A;
      end
    end
  endtask

  // Issue one op in the current cycle (cycle 0), wait for done, then observe one cycle further.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic m, output res_t res);
    start = 1'b1; dividend = a; divisor = b; mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom); mask = 1'($urandom);
    res.got = 1'b0;
    res.lat = 1;
    while (!res.got && res.lat <= 20) begin
      if (done === 1'b1) res.got = 1'b1;
      else begin
        @(posedge clk); #1;
        res.lat++;
      end
    end
    res.q = quotient; res.r = remainder; res.e = div_err;
    @(posedge clk); #1;
    res.done_after = done; res.busy_after = busy;
    res.q_after = quotient; res.r_after = remainder; res.e_after = div_err;
    $display("op %0d/%0d mask=%0d -> q=%0d r=%0d err=%0d cycle=%0d", a, b, m, res.q, res.r, res.e, res.lat);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, quotient, remainder, div_err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, quotient, remainder, div_err});
    end
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7; mask = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_start busy=%b want 0", busy);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] da [4];
    logic [7:0]  db [4], eq [4], er [4];
    logic        dm [4], ee [4];
    int          el [4];
    res_t        res;
    da = '{16'd1000, 16'd1000, 16'h1234, 16'h0900};
    db = '{8'd7, 8'd7, 8'd0, 8'd8};
    dm = '{1'b1, 1'b0, 1'b1, 1'b1};
    eq = '{8'd142, APPROX_Q, 8'hFF, 8'hFF};
    er = '{8'd6, 8'd0, 8'h34, 8'd0};
    ee = '{1'b0, 1'b0, 1'b1, 1'b1};
    el = '{9, 9 - A, 1, 1};
    for (int i = 0; i < 4; i++) begin
      do_op(da[i], db[i], dm[i], res);
      checks++;
      if (!res.got || res.lat != el[i]) begin
        errors++;
        $display("FAIL directed%0d_latency got done=%0d cycle=%0d want cycle=%0d", i, res.got, res.lat, el[i]);
      end
      checks++;
      if ({res.q, res.r, res.e} !== {eq[i], er[i], ee[i]}) begin
        errors++;
        $display("FAIL directed%0d_result got q=%0d r=%0d e=%0d want q=%0d r=%0d e=%0d",
                 i, res.q, res.r, res.e, eq[i], er[i], ee[i]);
      end
      checks++;
      if ({res.done_after, res.busy_after, res.q_after, res.r_after, res.e_after} !== {2'b00, eq[i], er[i], ee[i]}) begin
        errors++;
        $display("FAIL directed%0d_hold got done=%b busy=%b q=%0d r=%0d e=%b",
                 i, res.done_after, res.busy_after, res.q_after, res.r_after, res.e_after);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    int done_cyc = -1;
    logic [7:0] q = '0, r = '0;
    logic e = 1'b0;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7; mask = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = c; q = quotient; r = remainder; e = div_err;
        end
      end
      start = (c >= 3 && c <= 5);
      dividend = 16'h1234; divisor = 8'd0; mask = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (pulses != 1 || done_cyc != 9) begin
      errors++;
      $display("FAIL busy_start_done got pulses=%0d cycle=%0d want 1 at 9", pulses, done_cyc);
    end
    checks++;
    if ({q, r, e} !== {8'd142, 8'd6, 1'b0}) begin
      errors++;
      $display("FAIL busy_start_result got q=%0d r=%0d e=%0d want 142 6 0", q, r, e);
    end
    checks++;
    if ({quotient, remainder, div_err} !== {8'd142, 8'd6, 1'b0}) begin
      errors++;
      $display("FAIL busy_start_hold got q=%0d r=%0d e=%0d want 142 6 0", quotient, remainder, div_err);
    end
  endtask

  task automatic test_reset_mid();
    res_t res;
    int   stray = 0;
    do_op(16'd500, 8'd3, 1'b1, res);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7; mask = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || quotient !== 8'd166) begin
      errors++;
      $display("FAIL midreset_pre got busy=%b q=%0d want 1 166", busy, quotient);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_err} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 0", {busy, done, quotient, remainder, div_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d active cycles want 0", stray);
    end
    do_op(16'd255, 8'd1, 1'b1, res);
    checks++;
    if (!res.got || res.lat != 9 || {res.q, res.r, res.e} !== {8'd255, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_newop got cycle=%0d q=%0d r=%0d e=%0d want 9 255 0 0", res.lat, res.q, res.r, res.e);
    end
  endtask

  task automatic test_back_to_back();
    res_t res;
    do_op(16'd500, 8'd3, 1'b1, res);
    checks++;
    if (!res.got || res.lat != 9 || {res.q, res.r, res.e} !== {8'd166, 8'd2, 1'b0} || res.busy_after !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got cycle=%0d q=%0d r=%0d e=%0d busy_after=%b", res.lat, res.q, res.r, res.e, res.busy_after);
    end
    do_op(16'd65535, 8'd255, 1'b1, res);
    checks++;
    if (!res.got || res.lat != 1 || {res.q, res.r, res.e} !== {8'hFF, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got cycle=%0d q=%0d r=%0d e=%0d want 1 255 0 1", res.lat, res.q, res.r, res.e);
    end
  endtask

  task automatic test_random();
    res_t        res;
    logic [15:0] a;
    logic [7:0]  b, eq, er;
    logic        m, ee;
    int          el;
    for (int i = 0; i < 80; i++) begin
      b = 8'($urandom_range(0, 255));
      a = 16'($urandom);
      if (b != 8'd0 && $urandom_range(0, 3) != 0) a[15:8] = 8'($urandom_range(0, int'(b) - 1));
      m = 1'($urandom);
      model(a, b, m, eq, er, ee, el);
      do_op(a, b, m, res);
      checks++;
      if (!res.got || res.lat != el) begin
        errors++;
        $display("FAIL rand%0d_latency got done=%0d cycle=%0d want cycle=%0d", i, res.got, res.lat, el);
      end
      checks++;
      if ({res.q, res.r, res.e} !== {eq, er, ee}) begin
        errors++;
        $display("FAIL rand%0d_result %0d/%0d m=%0d got q=%0d r=%0d e=%0d want q=%0d r=%0d e=%0d",
                 i, a, b, m, res.q, res.r, res.e, eq, er, ee);
      end
      checks++;
      if ({res.done_after, res.q_after, res.r_after, res.e_after} !== {1'b0, eq, er, ee}) begin
        errors++;
        $display("FAIL rand%0d_hold got done=%b q=%0d r=%0d e=%b", i, res.done_after, res.q_after, res.r_after, res.e_after);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
